stopwatch_adjust_unit: RTL and testbench

- Preset, adjust and error-select unit for the 4-digit BCD stopwatch (MM:SS; digit ranges 1-4, 0-9, 0-5, 0-9).
- Computes a registered load word for the counter chain from the RESET, ADD and SUBTRACT requests, clamping to the legal window [10:20 .. 49:30].
- Also selects the 16-bit error pattern shown on the display when a control conflict is flagged.
- Sits between the control inputs and the counter loader and display mux.

---
 rtl/stopwatch_adjust_unit.sv | 173 +++++++++++++++++
 tb/tb_stopwatch_adjust_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_adjust_unit.sv
// stopwatch_adjust_unit
// Preset, +/-1 second adjust and error-pattern select for the MM:SS BCD
// stopwatch. Produces a registered load word and strobe for the counter chain
// and the registered error-display selection.
// Build option: define STOPWATCH_ADJUST_WRAP_EN to make out-of-window adjust
// results wrap to the opposite bound instead of clamping to the near one.
module stopwatch_adjust_unit #(
   parameter logic [15:0] MIN_VALUE = 16'h1020,
   parameter logic [15:0] MAX_VALUE = 16'h4930,
   parameter logic [15:0] ERR_CODE0 = 16'hEEEE,
   parameter logic [15:0] ERR_CODE1 = 16'h5555
) (
   input  logic        clk_in,
   input  logic        RESET,
   input  logic        REVERSE,
   input  logic        ADD,
   input  logic        SUBTRACT,
   input  logic [15:0] PREV_Q,
   input  logic        ERROR_1,
   input  logic        ERROR_2,
   output logic [15:0] LOAD_VALUE,
   output logic        LOAD_EN,
   output logic        OUT_OF_RANGE,
   output logic        ERROR_INDEX,
   output logic        ERROR_ACTIVE,
   output logic [15:0] ERROR_CODE
);

   // +1 second in mixed radix {m10, m1, s10, s1}
   function automatic logic [15:0] bcd_inc(input logic [15:0] q);
      logic [3:0] m10, m1, s10, s1;
      m10 = q[15:12];
      m1  = q[11:8];
      s10 = q[7:4];
      s1  = q[3:0];
      if (s1 == 4'd9) begin
         s1 = 4'd0;
         if (s10 == 4'd5) begin
            s10 = 4'd0;
            if (m1 == 4'd9) begin
               m1  = 4'd0;
               m10 = m10 + 4'd1;
            end else begin
               m1 = m1 + 4'd1;
            end
         end else begin
            s10 = s10 + 4'd1;
         end
      end else begin
         s1 = s1 + 4'd1;
      end
      return {m10, m1, s10, s1};
   endfunction

   // -1 second in mixed radix {m10, m1, s10, s1}
   function automatic logic [15:0] bcd_dec(input logic [15:0] q);
      logic [3:0] m10, m1, s10, s1;
      m10 = q[15:12];
      m1  = q[11:8];
      s10 = q[7:4];
      s1  = q[3:0];
      if (s1 == 4'd0) begin
         s1 = 4'd9;
         if (s10 == 4'd0) begin
            s10 = 4'd5;
            if (m1 == 4'd0) begin
               m1  = 4'd9;
               m10 = m10 - 4'd1;
            end else begin
               m1 = m1 - 4'd1;
            end
         end else begin
            s10 = s10 - 4'd1;
         end
      end else begin
         s1 = s1 - 4'd1;
      end
      return {m10, m1, s10, s1};
   endfunction

   // Any digit outside its legal range (m10 1..4, m1 0..9, s10 0..5, s1 0..9)
   function automatic logic digit_illegal(input logic [15:0] q);
      return (q[15:12] < 4'd1) || (q[15:12] > 4'd4) ||
             (q[11:8] > 4'd9) || (q[7:4] > 4'd5) || (q[3:0] > 4'd9);
   endfunction

   logic        r_add_d;
   logic        r_sub_d;
   logic [15:0] r_load_value;
   logic        r_load_en;
   logic        r_out_of_range;
   logic        r_error_index;
   logic        r_error_active;
   logic [15:0] r_error_code;

   logic        w_add_p;
   logic        w_sub_p;
   logic        w_adjust;
   logic [15:0] w_step;
   logic        w_oor;
   logic        w_idx;
   logic [15:0] w_adj_value;
   logic [15:0] w_preset;
   logic        w_error_index;

   assign w_add_p       = ADD & ~r_add_d;
   assign w_sub_p       = SUBTRACT & ~r_sub_d;
   assign w_adjust      = w_add_p ^ w_sub_p;
   assign w_preset      = REVERSE ? MAX_VALUE : MIN_VALUE;
   assign w_error_index = ERROR_2 & ~ERROR_1;

   // Adjust result, window check and clamp/wrap selection for the adjust path
   always_comb begin
      w_step      = 16'h0000;
      w_oor       = 1'b0;
      w_idx       = 1'b0;
      w_adj_value = 16'h0000;
      if (w_add_p) begin
         w_step = bcd_inc(PREV_Q);
      end else begin
         w_step = bcd_dec(PREV_Q);
      end
      // With legal input digits the BCD word orders like its magnitude
      w_oor = digit_illegal(PREV_Q) || (w_step > MAX_VALUE) || (w_step < MIN_VALUE);
`ifdef STOPWATCH_ADJUST_WRAP_EN
      w_idx = ~ADD;
`else
      w_idx = ADD;
`endif
      if (w_oor) begin
         w_adj_value = w_idx ? MAX_VALUE : MIN_VALUE;
      end else begin
         w_adj_value = w_step;
      end
   end

   // Registered load word/strobe, edge history and error selection
   always_ff @(posedge clk_in) begin
      if (RESET) begin
         r_add_d        <= ADD;
         r_sub_d        <= SUBTRACT;
         r_load_en      <= 1'b1;
         r_load_value   <= w_preset;
         r_out_of_range <= 1'b0;
         r_error_index  <= 1'b0;
         r_error_active <= 1'b0;
         r_error_code   <= ERR_CODE0;
      end else begin
         r_add_d        <= ADD;
         r_sub_d        <= SUBTRACT;
         r_error_index  <= w_error_index;
         r_error_active <= ERROR_1 | ERROR_2;
         r_error_code   <= w_error_index ? ERR_CODE1 : ERR_CODE0;
         if (w_adjust) begin
            r_load_en      <= 1'b1;
            r_load_value   <= w_adj_value;
            r_out_of_range <= w_oor;
         end else begin
            r_load_en      <= 1'b0;
            r_load_value   <= r_load_value;
            r_out_of_range <= 1'b0;
         end
      end
   end

   assign LOAD_VALUE   = r_load_value;
   assign LOAD_EN      = r_load_en;
   assign OUT_OF_RANGE = r_out_of_range;
   assign ERROR_INDEX  = r_error_index;
   assign ERROR_ACTIVE = r_error_active;
   assign ERROR_CODE   = r_error_code;

endmodule

// File: tb/tb_stopwatch_adjust_unit.sv
// Testbench for stopwatch_adjust_unit: directed scenarios plus randomized
// stimulus checked against a seconds-based reference model.
module tb_stopwatch_adjust_unit;

   localparam logic [15:0] MINV = 16'h1020;
   localparam logic [15:0] MAXV = 16'h4930;
`ifdef STOPWATCH_ADJUST_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   localparam logic [15:0] ADD_OVF_VAL = WRAP ? MINV : MAXV;
   localparam logic [15:0] SUB_UNF_VAL = WRAP ? MAXV : MINV;

   logic        clk_in = 1'b0;
   logic        RESET = 1'b0, REVERSE = 1'b0, ADD = 1'b0, SUBTRACT = 1'b0;
   logic [15:0] PREV_Q = 16'h0000;
   logic        ERROR_1 = 1'b0, ERROR_2 = 1'b0;
   logic [15:0] LOAD_VALUE, ERROR_CODE;
   logic        LOAD_EN, OUT_OF_RANGE, ERROR_INDEX, ERROR_ACTIVE;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   bit          m_add_d = 1'b0, m_sub_d = 1'b0;
   logic        e_load_en, e_oor, e_eidx, e_eact;
   logic [15:0] e_load_val = 16'h0000, e_ecode;

   stopwatch_adjust_unit dut (
      .clk_in(clk_in), .RESET(RESET), .REVERSE(REVERSE), .ADD(ADD),
      .SUBTRACT(SUBTRACT), .PREV_Q(PREV_Q), .ERROR_1(ERROR_1), .ERROR_2(ERROR_2),
      .LOAD_VALUE(LOAD_VALUE), .LOAD_EN(LOAD_EN), .OUT_OF_RANGE(OUT_OF_RANGE),
      .ERROR_INDEX(ERROR_INDEX), .ERROR_ACTIVE(ERROR_ACTIVE), .ERROR_CODE(ERROR_CODE)
   );

   always #5 clk_in = ~clk_in;

   function automatic int to_sec(input logic [15:0] q);
      return int'(q[15:12]) * 600 + int'(q[11:8]) * 60 + int'(q[7:4]) * 10 + int'(q[3:0]);
   endfunction

   function automatic logic [15:0] from_sec(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic bit bad_digits(input logic [15:0] q);
      return (q[15:12] < 1) || (q[15:12] > 4) || (q[11:8] > 9) || (q[7:4] > 5) || (q[3:0] > 9);
   endfunction

   // Expected outputs after the next rising edge for the given inputs
   task automatic predict(input bit rst, input bit rev, input bit add, input bit sub,
                          input logic [15:0] q, input bit e1, input bit e2);
      bit ap, sp, bad, idx;
      int ns;
      if (rst) begin
         e_load_en = 1'b1; e_load_val = rev ? MAXV : MINV; e_oor = 1'b0;
         e_eidx = 1'b0; e_eact = 1'b0; e_ecode = 16'hEEEE;
      end else begin
         ap = add && !m_add_d;
         sp = sub && !m_sub_d;
         e_eidx = e2 && !e1;
         e_eact = e1 || e2;
         e_ecode = e_eidx ? 16'h5555 : 16'hEEEE;
         if (ap != sp) begin
            ns = to_sec(q) + (ap ? 1 : -1);
            bad = bad_digits(q) || ns < to_sec(MINV) || ns > to_sec(MAXV);
            idx = WRAP ? !add : add;
            e_load_en = 1'b1;
            e_oor = bad;
            e_load_val = bad ? (idx ? MAXV : MINV) : from_sec(ns);
         end else begin
            e_load_en = 1'b0;
            e_oor = 1'b0;
         end
      end
      m_add_d = add;
      m_sub_d = sub;
   endtask

   // Drive one cycle of inputs, update the model, and advance past the edge
   task automatic cyc(input bit rst, input bit rev, input bit add, input bit sub,
                      input logic [15:0] q, input bit e1, input bit e2);
      RESET = rst; REVERSE = rev; ADD = add; SUBTRACT = sub; PREV_Q = q;
      ERROR_1 = e1; ERROR_2 = e2;
      predict(rst, rev, add, sub, q, e1, e2);
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 16'h2233, 1, 1);
      n_vec++; if (LOAD_EN !== 1'b1) begin n_err++; $display("FAIL reset0_load_en got %b exp 1", LOAD_EN); end
      n_vec++; if (LOAD_VALUE !== 16'h1020) begin n_err++; $display("FAIL reset0_value got %h exp 1020", LOAD_VALUE); end
      n_vec++; if (ERROR_ACTIVE !== 1'b0) begin n_err++; $display("FAIL reset0_err_active got %b exp 0", ERROR_ACTIVE); end
      n_vec++; if (ERROR_CODE !== 16'hEEEE) begin n_err++; $display("FAIL reset0_err_code got %h exp eeee", ERROR_CODE); end
      cyc(1, 1, 0, 0, 16'h2233, 0, 1);
      n_vec++; if (LOAD_EN !== 1'b1) begin n_err++; $display("FAIL reset1_load_en got %b exp 1", LOAD_EN); end
      n_vec++; if (LOAD_VALUE !== 16'h4930) begin n_err++; $display("FAIL reset1_value got %h exp 4930", LOAD_VALUE); end
      n_vec++; if (ERROR_ACTIVE !== 1'b0 || ERROR_INDEX !== 1'b0) begin n_err++; $display("FAIL reset1_err got act=%b idx=%b exp 0 0", ERROR_ACTIVE, ERROR_INDEX); end
      n_vec++; if (OUT_OF_RANGE !== 1'b0) begin n_err++; $display("FAIL reset1_oor got %b exp 0", OUT_OF_RANGE); end
   endtask

   task automatic test_add_sub();
      cyc(0, 0, 0, 0, 16'h1059, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b0) begin n_err++; $display("FAIL idle_load_en got %b exp 0", LOAD_EN); end
      cyc(0, 0, 1, 0, 16'h1059, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b1 || LOAD_VALUE !== 16'h1100 || OUT_OF_RANGE !== 1'b0) begin
         n_err++; $display("FAIL add_carry got en=%b val=%h oor=%b exp 1 1100 0", LOAD_EN, LOAD_VALUE, OUT_OF_RANGE); end
      cyc(0, 0, 1, 0, 16'h1100, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b0 || LOAD_VALUE !== 16'h1100) begin
         n_err++; $display("FAIL add_held got en=%b val=%h exp 0 1100", LOAD_EN, LOAD_VALUE); end
      cyc(0, 0, 0, 0, 16'h1100, 0, 0);
      cyc(0, 0, 0, 1, 16'h1100, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b1 || LOAD_VALUE !== 16'h1059 || OUT_OF_RANGE !== 1'b0) begin
         n_err++; $display("FAIL sub_borrow got en=%b val=%h oor=%b exp 1 1059 0", LOAD_EN, LOAD_VALUE, OUT_OF_RANGE); end
      cyc(0, 0, 0, 0, 16'h1020, 0, 0);
      cyc(0, 0, 0, 1, 16'h1020, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b1 || LOAD_VALUE !== SUB_UNF_VAL || OUT_OF_RANGE !== 1'b1) begin
         n_err++; $display("FAIL sub_underflow got en=%b val=%h oor=%b exp 1 %h 1", LOAD_EN, LOAD_VALUE, OUT_OF_RANGE, SUB_UNF_VAL); end
      cyc(0, 0, 0, 0, 16'h4930, 0, 0);
      n_vec++; if (OUT_OF_RANGE !== 1'b0) begin n_err++; $display("FAIL oor_pulse got %b exp 0", OUT_OF_RANGE); end
      cyc(0, 0, 1, 0, 16'h4930, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b1 || LOAD_VALUE !== ADD_OVF_VAL || OUT_OF_RANGE !== 1'b1) begin
         n_err++; $display("FAIL add_overflow got en=%b val=%h oor=%b exp 1 %h 1", LOAD_EN, LOAD_VALUE, OUT_OF_RANGE, ADD_OVF_VAL); end
      cyc(0, 0, 0, 0, 16'h4930, 0, 0);
   endtask

   task automatic test_conflicts();
      cyc(0, 0, 1, 1, 16'h2000, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b0) begin n_err++; $display("FAIL both_edges got en=%b exp 0", LOAD_EN); end
      cyc(0, 0, 0, 0, 16'h2000, 0, 0);
      cyc(1, 1, 1, 0, 16'h1059, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b1 || LOAD_VALUE !== 16'h4930) begin
         n_err++; $display("FAIL reset_priority got en=%b val=%h exp 1 4930", LOAD_EN, LOAD_VALUE); end
      cyc(0, 1, 1, 0, 16'h1059, 0, 0);
      n_vec++; if (LOAD_EN !== 1'b0) begin n_err++; $display("FAIL held_through_reset got en=%b exp 0", LOAD_EN); end
      cyc(0, 0, 0, 0, 16'h1059, 0, 0);
   endtask

   task automatic test_errors();
      cyc(0, 0, 0, 0, 16'h2000, 1, 1);
      n_vec++; if (ERROR_INDEX !== 1'b0 || ERROR_CODE !== 16'hEEEE || ERROR_ACTIVE !== 1'b1) begin
         n_err++; $display("FAIL err_both got idx=%b code=%h act=%b exp 0 eeee 1", ERROR_INDEX, ERROR_CODE, ERROR_ACTIVE); end
      cyc(0, 0, 0, 0, 16'h2000, 0, 1);
      n_vec++; if (ERROR_INDEX !== 1'b1 || ERROR_CODE !== 16'h5555 || ERROR_ACTIVE !== 1'b1) begin
         n_err++; $display("FAIL err_two got idx=%b code=%h act=%b exp 1 5555 1", ERROR_INDEX, ERROR_CODE, ERROR_ACTIVE); end
      cyc(0, 0, 0, 0, 16'h2000, 0, 0);
      n_vec++; if (ERROR_ACTIVE !== 1'b0 || ERROR_CODE !== 16'hEEEE) begin
         n_err++; $display("FAIL err_none got act=%b code=%h exp 0 eeee", ERROR_ACTIVE, ERROR_CODE); end
   endtask

   task automatic test_random();
      logic [15:0] q;
      logic [15:0] edges [6];
      edges[0] = 16'h1020; edges[1] = 16'h1021; edges[2] = 16'h4930;
      edges[3] = 16'h4929; edges[4] = 16'h4959; edges[5] = 16'h1000;
      for (int i = 0; i < 500; i++) begin
         case ($urandom_range(0, 7))
            0: q = 16'($urandom);
            1, 2: q = edges[$urandom_range(0, 5)];
            default: q = {4'($urandom_range(1, 4)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
         endcase
         cyc(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             q, 1'($urandom), 1'($urandom));
         n_vec++; if (LOAD_EN !== e_load_en) begin n_err++; $display("FAIL rnd%0d load_en got %b exp %b", i, LOAD_EN, e_load_en); end
         n_vec++; if (LOAD_VALUE !== e_load_val) begin n_err++; $display("FAIL rnd%0d load_value got %h exp %h q=%h", i, LOAD_VALUE, e_load_val, q); end
         n_vec++; if (OUT_OF_RANGE !== e_oor) begin n_err++; $display("FAIL rnd%0d oor got %b exp %b q=%h", i, OUT_OF_RANGE, e_oor, q); end
         n_vec++; if (ERROR_INDEX !== e_eidx) begin n_err++; $display("FAIL rnd%0d err_index got %b exp %b", i, ERROR_INDEX, e_eidx); end
         n_vec++; if (ERROR_ACTIVE !== e_eact) begin n_err++; $display("FAIL rnd%0d err_active got %b exp %b", i, ERROR_ACTIVE, e_eact); end
         n_vec++; if (ERROR_CODE !== e_ecode) begin n_err++; $display("FAIL rnd%0d err_code got %h exp %h", i, ERROR_CODE, e_ecode); end
      end
   endtask

   initial begin
      @(posedge clk_in);
      #1;
      test_reset();
      test_add_sub();
      test_conflicts();
      test_errors();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
